ifetch_queue: RTL
=================

// Module: ifetch_queue
// PURPOSE
//   Fetch control between the PC register and the IF/ID boundary. Computes next PC (pc+4 or redirect),
//   drives the PC write-enable, issues one instruction-memory read at a time, and buffers {pc,instr}
//   pairs in a small FIFO that feeds decode. Branch/jump redirects flush the queue and kill in-flight reads.
// PARAMETERS
//   DEPTH    4   fetch-queue entries; power of 2, >=2
//   ADDR_W  32   PC / memory address width
// PORTS
//   clk          in   1       system clock; all state on posedge
//   reset        in   1       synchronous, active-high; clears all state
//   pc_cur       in   ADDR_W  current PC (PC register output)
//   pc_next      out  ADDR_W  value to load into PC (PC input)
//   pc_en        out  1       PC write enable
//   redirect     in   1       branch/jump taken this cycle (from ID/EX)
//   redirect_pc  in   ADDR_W  redirect target; bits [1:0] are forced to 00
//   imem_req     out  1       read request
//   imem_addr    out  ADDR_W  read address (= pc_cur)
//   imem_ready   in   1       memory accepts request this cycle
//   imem_rvalid  in   1       read data valid (in order, >=1 cycle after accept)
//   imem_rdata   in   32      instruction word
//   id_valid     out  1       queue head valid
//   id_ready     in   1       decode consumes head
//   id_pc        out  ADDR_W  PC of head instruction
//   id_instr     out  32      head instruction
// BEHAVIOUR
//   State: FIFO (count 0..DEPTH), outstanding (1 read in flight), req_pc (address of in-flight read),
//     drop (in-flight response is stale).
//   Reset: count=0, outstanding=0, drop=0. Combinational outputs during/after reset: imem_req=0,
//     pc_en=0, id_valid=0. The PC register resets itself to 32'h00003000.
//   Issue: can_issue = !redirect && (!outstanding || imem_rvalid) && (count + outstanding < DEPTH).
//     imem_req=can_issue; imem_addr=pc_cur. Accept = imem_req && imem_ready.
//     The slot reserved by outstanding guarantees a push never hits a full FIFO.
//   On accept: pc_en=1, pc_next=pc_cur+4 (wraps mod 2^ADDR_W), req_pc<=pc_cur, outstanding<=1.
//     pc_cur is stable while a request is held and not accepted.
//   Response (imem_rvalid && outstanding): if drop or redirect this cycle, discard and clear drop.
//     Otherwise push {req_pc, imem_rdata}. outstanding clears unless an accept happens in the same
//     cycle (back-to-back: 1 instr/cycle). rvalid with !outstanding is ignored (protocol error).
//   Decode: id_valid=(count!=0); id_pc/id_instr=head. Pop on id_valid && id_ready.
//     Push+pop in the same cycle leaves count unchanged.
//   Redirect (highest priority): pc_en=1, pc_next={redirect_pc[ADDR_W-1:2],2'b00}; no request this
//     cycle. FIFO flush: count<=0, and a same-cycle pop or push is void. If outstanding and no
//     rvalid this cycle: drop<=1 and the response arrives later.
//   Repeated redirects while drop=1 keep drop=1 (only one read is ever in flight).
//   Latency: accept at cycle N, rvalid at N+k -> id_valid at N+k+1 if the queue was empty.
// STRUCTURE
//   mips_pkg: RESET_PC=32'h00003000, INSTR_W=32, NOP=32'h0000_0000.
//   Sub-module sync_fifo #(WIDTH=ADDR_W+32, DEPTH): push/pop/flush, count, head data. Sync reset.
//   Issue/response/redirect control stays in ifetch_queue.
// TESTING
//   1 Reset, then imem_ready=1 and rvalid 1 cycle after accept, id_ready=1: imem_addr 3000,3004,3008
//     on consecutive cycles; id_pc follows 1 cycle behind rvalid; 1 instr/cycle sustained.
//   2 id_ready=0, memory always ready: exactly DEPTH=4 entries (3000..300C) queued; imem_req drops
//     to 0 with one slot reserved; pc_cur halts at 3010. Release id_ready: fetch resumes at 3010.
//   3 Redirect to 32'h00003403 with 2 entries queued and a read in flight: pc_next=3400, id_valid=0
//     next cycle, late rvalid discarded, first new entry is id_pc=3400.
//   4 Redirect in the same cycle as rvalid and id_ready: response discarded, no pop, count=0.
//     No request in the redirect cycle; request for the target on the next cycle.
//   5 imem_ready low 3 cycles: imem_req held, imem_addr stable at 3000, pc_en=0 until accept.
//   6 Reset asserted mid-fetch (read outstanding, queue 2): next cycle id_valid=0 and imem_req=0;
//     no push from a stale rvalid after reset.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS front end.
package mips_pkg;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          INSTR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; head data is always presented on rdata.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // flush voids any same-cycle push or pop
  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = push && !flush && ((count != FULL) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/ifetch_queue.sv
// Fetch control: next-PC select, single outstanding imem read, and a {pc,instr}
// queue feeding decode. Redirects flush the queue and squash the in-flight read.
module ifetch_queue
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_cur,
  output logic [ADDR_W-1:0]  pc_next,
  output logic               pc_en,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INSTR_W-1:0] id_instr
);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  logic              outstanding, drop;
  logic [ADDR_W-1:0] req_pc;
  logic [CW-1:0]     count;
  fetch_entry_t      wentry, head;
  logic              room, can_issue, accept, resp, push, pop;

  // the in-flight read holds a reserved slot, so a push never sees a full queue
  assign room      = ({1'b0, count} + (CW+1)'(outstanding)) < (CW+1)'(DEPTH);
  assign can_issue = !reset && !redirect && (!outstanding || imem_rvalid) && room;
  assign imem_req  = can_issue;
  assign imem_addr = pc_cur;
  assign accept    = can_issue && imem_ready;

  assign resp     = imem_rvalid && outstanding;
  assign push     = resp && !drop && !redirect && !reset;
  assign id_valid = !reset && (count != '0);
  assign pop      = id_valid && id_ready && !redirect;

  assign pc_en   = !reset && (redirect || accept);
  assign pc_next = redirect ? (redirect_pc & ~ADDR_W'(3)) : pc_cur + ADDR_W'(4);

  assign wentry = '{pc: req_pc, instr: imem_rdata};

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wentry),
    .rdata (head),
    .count (count)
  );

  assign id_pc    = head.pc;
  assign id_instr = id_valid ? head.instr : NOP;

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else begin
      if (accept)    outstanding <= 1'b1;
      else if (resp) outstanding <= 1'b0;
      // a squashed read still returns data later; remember to discard it
      if (resp)                         drop <= 1'b0;
      else if (redirect && outstanding) drop <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) req_pc <= pc_cur;
  end
endmodule
